// File: rtl/seg_scan_driver.sv
// Time-multiplexed hex 7-segment scan driver with dead time and frame-aligned value loading.
// Define SEG_SCAN_LZB_EN to blank leading zeros on digits above digit 0.
module seg_scan_driver #(
   parameter int DIGITS     = 4,
   parameter int SCAN_DIV   = 1024,
   parameter int ACTIVE_LOW = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   value,
   input  logic                  load,
   output logic                  pending,
   output logic [6:0]            segs,
   output logic [DIGITS-1:0]     digit_sel,
   output logic                  frame_start
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PW = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);
   localparam logic POL = (ACTIVE_LOW != 0);

   logic [PW-1:0]          r_pcnt;
   logic [IW-1:0]          r_idx;
   logic [4*DIGITS-1:0]    r_disp;
   logic [4*DIGITS-1:0]    r_pend;
   logic                   r_pending;
   logic                   r_started;
   logic                   r_frame;
   logic [6:0]             r_segs;
   logic [DIGITS-1:0]      r_sel;

   logic                   w_pwrap;
   logic                   w_boundary;
   logic [3:0]             w_nib;
   logic                   w_blank;
   logic [6:0]             w_segs;
   logic [DIGITS-1:0]      w_sel;

   function automatic logic [6:0] hex_decode(input logic [3:0] n);
      case (n)
         4'h0: hex_decode = 7'h3F;
         4'h1: hex_decode = 7'h06;
         4'h2: hex_decode = 7'h5B;
         4'h3: hex_decode = 7'h4F;
         4'h4: hex_decode = 7'h66;
         4'h5: hex_decode = 7'h6D;
         4'h6: hex_decode = 7'h7D;
         4'h7: hex_decode = 7'h07;
         4'h8: hex_decode = 7'h7F;
         4'h9: hex_decode = 7'h6F;
         4'hA: hex_decode = 7'h77;
         4'hB: hex_decode = 7'h7C;
         4'hC: hex_decode = 7'h39;
         4'hD: hex_decode = 7'h5E;
         4'hE: hex_decode = 7'h79;
         default: hex_decode = 7'h71;
      endcase
   endfunction

   assign w_pwrap    = (r_pcnt == P_LAST);
   assign w_boundary = w_pwrap && (r_idx == I_LAST);

   always_comb begin
      w_nib   = 4'h0;
      w_sel   = '0;
      w_blank = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (r_idx == IW'(k)) begin
            w_nib    = r_disp[k*4 +: 4];
            // pcnt==0 is the anti-ghosting dead-time cycle
            w_sel[k] = (r_pcnt != '0);
         end
      end
`ifdef SEG_SCAN_LZB_EN
      for (int k = 1; k < DIGITS; k++) begin
         if (r_idx == IW'(k)) w_blank = ((r_disp >> (4*k)) == '0);
      end
`endif
      w_segs = w_blank ? 7'h00 : hex_decode(w_nib);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pcnt    <= '0;
         r_idx     <= '0;
         r_disp    <= '0;
         r_pend    <= '0;
         r_pending <= 1'b0;
         r_started <= 1'b0;
         r_frame   <= 1'b0;
         r_segs    <= {7{POL}};
         r_sel     <= {DIGITS{POL}};
      end else begin
         r_pcnt <= w_pwrap ? '0 : r_pcnt + 1'b1;
         if (w_pwrap) r_idx <= (r_idx == I_LAST) ? '0 : r_idx + 1'b1;

         // A load coinciding with the boundary bypasses pend and beats any older pending value
         if (w_boundary) begin
            r_started <= 1'b1;
            r_pending <= 1'b0;
            if (load)           r_disp <= value;
            else if (r_pending) r_disp <= r_pend;
         end else if (load) begin
            r_pend    <= value;
            r_pending <= 1'b1;
         end

         r_segs  <= w_segs ^ {7{POL}};
         r_sel   <= w_sel ^ {DIGITS{POL}};
         r_frame <= r_started && (r_pcnt == '0) && (r_idx == '0);
      end
   end

   assign pending     = r_pending;
   assign segs        = r_segs;
   assign digit_sel   = r_sel;
   assign frame_start = r_frame;

endmodule
